// File: rtl/pipe_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg + pipe_control_unit
//
// Purpose
//   Decodes the instruction in the decode slot into a 17-bit control word and
//   carries that word, its valid bit and its destination register down a short
//   chain of registered stages (stage 0 = EX). The unit also raises a load-use
//   stall request and a sticky halt flag.
//
// Configuration
//   CU_HALT_DRAIN_EN  defined   : halt rises on the edge where the HALT control
//                                 word leaves the last stage (pipeline drained).
//                     undefined : halt rises on the edge after the HALT control
//                                 word enters stage 0.
//
// Parameters
//   STAGES    number of registered stages after decode, legal 1..4.
//
// Ports
//   CLK       in   1            clock, rising edge
//   nRST      in   1            synchronous active-low reset
//   instr     in   32           decode-slot instruction word
//   en        in   1            pipeline advance enable
//   flush     in   1            squash the decode slot (taken branch/jump)
//   dec_cw    out  17           combinational control word for instr
//   cw_q      out  17*STAGES    registered control words, stage k at [17k+16:17k]
//   vld_q     out  STAGES       per-stage valid bits
//   hz_stall  out  1            load-use stall request to fetch/PC
//   halt      out  1            sticky halt
// -----------------------------------------------------------------------------

package cpu_types_pkg;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    J     = 6'b000010,
    JAL   = 6'b000011,
    BEQ   = 6'b000100,
    BNE   = 6'b000101,
    ADDI  = 6'b001000,
    ADDIU = 6'b001001,
    SLTI  = 6'b001010,
    SLTIU = 6'b001011,
    ANDI  = 6'b001100,
    ORI   = 6'b001101,
    XORI  = 6'b001110,
    LUI   = 6'b001111,
    LW    = 6'b100011,
    SW    = 6'b101011,
    HALT  = 6'b111111
  } opcode_t;

  typedef enum logic [5:0] {
    SLL  = 6'b000000,
    SRL  = 6'b000010,
    JR   = 6'b001000,
    ADD  = 6'b100000,
    ADDU = 6'b100001,
    SUB  = 6'b100010,
    SUBU = 6'b100011,
    AND  = 6'b100100,
    OR   = 6'b100101,
    XOR  = 6'b100110,
    NOR  = 6'b100111,
    SLT  = 6'b101010,
    SLTU = 6'b101011
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000,
    ALU_SRL  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_OR   = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010,
    ALU_SLTU = 4'b1011
  } aluop_t;

  // Field order is MSB first so the packed value matches the bit layout
  // [16] branch ... [3:0] aluop.
  typedef struct packed {
    logic       branch;
    logic       halt;
    logic [1:0] pc_src;
    logic       dmem_wen;
    logic       dmem_ren;
    logic [1:0] mem_to_reg;
    logic       reg_wen;
    logic [1:0] reg_dest;
    logic       ext_op;
    logic       alu_src;
    aluop_t     aluop;
  } cw_t;

  localparam int CW_W = $bits(cw_t);

  // reg_dest encodings
  localparam logic [1:0] DEST_RD = 2'd0;
  localparam logic [1:0] DEST_RT = 2'd1;
  localparam logic [1:0] DEST_RA = 2'd2;

  // pc_src encodings
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

endpackage

module pipe_control_unit
  import cpu_types_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [31:0]              instr,
  input  logic                     en,
  input  logic                     flush,
  output logic [16:0]              dec_cw,
  output logic [17*STAGES-1:0]     cw_q,
  output logic [STAGES-1:0]        vld_q,
  output logic                     hz_stall,
  output logic                     halt
);

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  opcode_t    opcode;
  funct_t     funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign opcode       = opcode_t'(instr[31:26]);
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = funct_t'(instr[5:0]);
  assign unused_shamt = ^instr[10:6];

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  cw_t        dec;
  logic [4:0] dec_dst;
  logic       reads_rt;

  always_comb begin
    // NOTE: every field gets a default before the case so no path through the
    // decode leaves a field unassigned, which would otherwise infer a latch.
    dec          = '0;
    dec.aluop    = ALU_ADD;
    dec.reg_dest = DEST_RT;
    dec.reg_wen  = 1'b1;

    case (opcode)
      RTYPE: begin
        dec.reg_dest = DEST_RD;
        case (funct)
          SLL:       dec.aluop = ALU_SLL;
          SRL:       dec.aluop = ALU_SRL;
          JR: begin
            dec.reg_wen = 1'b0;
            dec.pc_src  = PC_JR;
          end
          ADD, ADDU: dec.aluop = ALU_ADD;
          SUB, SUBU: dec.aluop = ALU_SUB;
          AND:       dec.aluop = ALU_AND;
          OR:        dec.aluop = ALU_OR;
          XOR:       dec.aluop = ALU_XOR;
          NOR:       dec.aluop = ALU_NOR;
          SLT:       dec.aluop = ALU_SLT;
          SLTU:      dec.aluop = ALU_SLTU;
          default:   dec.aluop = ALU_AND;
        endcase
      end

      ADDI, ADDIU: begin
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
      end

      SLTI: begin
        dec.aluop   = ALU_SLT;
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
      end

      SLTIU: begin
        dec.aluop   = ALU_SLTU;
        dec.alu_src = 1'b1;
        dec.ext_op  = 1'b1;
      end

      // Logical immediates are zero-extended.
      ANDI: begin
        dec.aluop   = ALU_AND;
        dec.alu_src = 1'b1;
      end

      ORI: begin
        dec.aluop   = ALU_OR;
        dec.alu_src = 1'b1;
      end

      XORI: begin
        dec.aluop   = ALU_XOR;
        dec.alu_src = 1'b1;
      end

      LUI: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 2'd2;
      end

      LW: begin
        dec.alu_src    = 1'b1;
        dec.ext_op     = 1'b1;
        dec.mem_to_reg = 2'd1;
        dec.dmem_ren   = 1'b1;
      end

      SW: begin
        dec.alu_src  = 1'b1;
        dec.ext_op   = 1'b1;
        dec.dmem_wen = 1'b1;
        dec.reg_wen  = 1'b0;
      end

      BEQ: begin
        dec.aluop   = ALU_SUB;
        dec.ext_op  = 1'b1;
        dec.pc_src  = PC_BR;
        dec.branch  = 1'b1;
        dec.reg_wen = 1'b0;
      end

      BNE: begin
        dec.aluop   = ALU_SUB;
        dec.ext_op  = 1'b1;
        dec.pc_src  = PC_BR;
        dec.reg_wen = 1'b0;
      end

      J: begin
        dec.pc_src  = PC_JMP;
        dec.reg_wen = 1'b0;
      end

      JAL: begin
        dec.pc_src     = PC_JMP;
        dec.reg_dest   = DEST_RA;
        dec.mem_to_reg = 2'd3;
      end

      HALT: begin
        dec.halt    = 1'b1;
        dec.reg_wen = 1'b0;
      end

      // Unrecognised opcodes must not disturb architectural state.
      default: dec.reg_wen = 1'b0;
    endcase
  end

  // Destination register carried with the control word; 0 means "no write",
  // which also keeps $0 out of the hazard comparison.
  always_comb begin
    dec_dst = 5'd0;
    if (dec.reg_wen) begin
      case (dec.reg_dest)
        DEST_RD: dec_dst = rd;
        DEST_RT: dec_dst = rt;
        DEST_RA: dec_dst = 5'd31;
        default: dec_dst = 5'd0;
      endcase
    end
  end

  // Only these formats read rt as a source; elsewhere rt is a destination.
  always_comb begin
    reads_rt = 1'b0;
    case (opcode)
      RTYPE, BEQ, BNE, SW: reads_rt = 1'b1;
      default:             reads_rt = 1'b0;
    endcase
  end

  assign dec_cw = dec;

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  cw_t               cw_r  [STAGES];
  logic [4:0]        dst_r [STAGES];
  logic [STAGES-1:0] vld_r;
  logic              halt_seen;
  logic              halt_r;

  // Load-use: a load sitting in stage 0 whose result the decode slot needs.
  // A flush squashes the decode slot, so there is nothing left to stall.
  assign hz_stall = !flush
                 && vld_r[0]
                 && cw_r[0].dmem_ren
                 && (dst_r[0] != 5'd0)
                 && ((dst_r[0] == rs) || (reads_rt && (dst_r[0] == rt)));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      // NOTE: these arrays are a few pipeline flops, not a RAM, so clearing
      // them all in reset is cheap and guarantees no stale in-flight work.
      for (int k = 0; k < STAGES; k++) begin
        cw_r[k]  <= '0;
        dst_r[k] <= '0;
      end
      vld_r     <= '0;
      halt_seen <= 1'b0;
      halt_r    <= 1'b0;
    end else begin
      if (en) begin
        // NOTE: non-blocking so each stage captures its predecessor's value
        // from before the edge, independent of statement order.
        for (int k = 1; k < STAGES; k++) begin
          cw_r[k]  <= cw_r[k-1];
          dst_r[k] <= dst_r[k-1];
          vld_r[k] <= vld_r[k-1];
        end

        if (flush || hz_stall || halt_seen) begin
          cw_r[0]  <= '0;
          dst_r[0] <= '0;
          vld_r[0] <= 1'b0;
        end else begin
          cw_r[0]  <= dec;
          dst_r[0] <= dec_dst;
          vld_r[0] <= 1'b1;
          if (dec.halt) begin
            halt_seen <= 1'b1;
          end
        end
      end

`ifdef CU_HALT_DRAIN_EN
      // Halt once the HALT word shifts out of the last stage.
      if (en && vld_r[STAGES-1] && cw_r[STAGES-1].halt) begin
        halt_r <= 1'b1;
      end
`else
      // Halt one edge after the HALT word was accepted into stage 0.
      if (halt_seen) begin
        halt_r <= 1'b1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cw_q = '0;
    for (int k = 0; k < STAGES; k++) begin
      cw_q[CW_W*k +: CW_W] = cw_r[k];
    end
  end

  assign vld_q = vld_r;
  assign halt  = halt_r;

endmodule

// File: tb/tb_pipe_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_control_unit
//
// Scoreboard bench for pipe_control_unit with STAGES=3. The driver applies one
// vector per clock (1 time unit after the rising edge) and pushes the expected
// snapshot: registered state produced by that edge plus the combinational
// outputs for the newly applied inputs. The monitor pops one entry on each
// falling edge and compares it with the DUT. Honours CU_HALT_DRAIN_EN.
// -----------------------------------------------------------------------------
module tb_pipe_control_unit;

  localparam int STAGES = 3;

`ifdef CU_HALT_DRAIN_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] instr;
  logic        en;
  logic        flush;
  logic [16:0] dec_cw;
  logic [50:0] cw_q;
  logic [2:0]  vld_q;
  logic        hz_stall;
  logic        halt;

  always #5 CLK = ~CLK;

  pipe_control_unit #(.STAGES(STAGES)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .instr    (instr),
    .en       (en),
    .flush    (flush),
    .dec_cw   (dec_cw),
    .cw_q     (cw_q),
    .vld_q    (vld_q),
    .hz_stall (hz_stall),
    .halt     (halt)
  );

  typedef struct {
    string       name;
    logic [50:0] cw;
    logic [2:0]  vld;
    logic [16:0] dec;
    logic        hz;
    logic        hlt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  // Packs fields into the 17-bit control word layout.
  function automatic logic [16:0] mk(input int aluop, input bit alu_src,
                                     input bit ext_op, input int reg_dest,
                                     input bit reg_wen, input int mem_to_reg,
                                     input bit ren, input bit wen,
                                     input int pc_src, input bit hlt,
                                     input bit br);
    logic [3:0] a;
    logic [1:0] d;
    logic [1:0] m;
    logic [1:0] p;
    a = aluop[3:0];
    d = reg_dest[1:0];
    m = mem_to_reg[1:0];
    p = pc_src[1:0];
    return {br, hlt, p, wen, ren, m, reg_wen, d, ext_op, alu_src, a};
  endfunction

  function automatic logic [31:0] rtype(input int rs, input int rt,
                                        input int rd, input int fn);
    logic [4:0] s, t, d;
    logic [5:0] f;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0]; f = fn[5:0];
    return {6'd0, s, t, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs,
                                        input int rt, input int imm);
    logic [5:0]  o;
    logic [4:0]  s, t;
    logic [15:0] i;
    o = op[5:0]; s = rs[4:0]; t = rt[4:0]; i = imm[15:0];
    return {o, s, t, i};
  endfunction

  task automatic cyc(input string name, input logic rst_v, input logic en_v,
                     input logic fl_v, input logic [31:0] i,
                     input logic [16:0] c2, input logic [16:0] c1,
                     input logic [16:0] c0, input logic [2:0] v,
                     input logic [16:0] d, input logic h, input logic hl);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST  = rst_v;
    en    = en_v;
    flush = fl_v;
    instr = i;
    e.name = name;
    e.cw   = {c2, c1, c0};
    e.vld  = v;
    e.dec  = d;
    e.hz   = h;
    e.hlt  = hl;
    sb.push_back(e);
  endtask

  // Monitor: compare one expected snapshot per falling edge.
  initial begin
    forever begin
      exp_t e;
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "cw_q",     64'(cw_q),     64'(e.cw));
        check(e.name, "vld_q",    64'(vld_q),    64'(e.vld));
        check(e.name, "dec_cw",   64'(dec_cw),   64'(e.dec));
        check(e.name, "hz_stall", 64'(hz_stall), 64'(e.hz));
        check(e.name, "halt",     64'(halt),     64'(e.hlt));
      end
    end
  end

  // Expected control words (hand-derived from the decode table).
  logic [16:0] Z, NOP, C_ADDU, C_ORI, C_LW, C_ADDI, C_BEQ, C_SW, C_JAL, C_HLT, C_AND;
  logic [31:0] i_addu, i_ori, i_lw5, i_addu6, i_lw0, i_addu8, i_lw10;
  logic [31:0] i_ori10, i_beq, i_sw, i_bad, i_addu12, i_jal, i_halt, i_addi;

  initial begin
    nRST  = 1'b0;
    en    = 1'b0;
    flush = 1'b0;
    instr = 32'd0;

    Z      = 17'd0;
    NOP    = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    C_ADDU = mk(2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    C_ORI  = mk(5, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    C_LW   = mk(2, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
    C_ADDI = mk(2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    C_BEQ  = mk(3, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    C_SW   = mk(2, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    C_JAL  = mk(2, 0, 0, 2, 1, 3, 0, 0, 2, 0, 0);
    C_HLT  = mk(2, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    C_AND  = mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    i_addu   = rtype(1, 2, 3, 'h21);     // ADDU $3,$1,$2
    i_ori    = itype('h0D, 1, 4, 'hFF);  // ORI  $4,$1,0xff
    i_lw5    = itype('h23, 1, 5, 0);     // LW   $5,0($1)
    i_addu6  = rtype(5, 7, 6, 'h21);     // ADDU $6,$5,$7
    i_lw0    = itype('h23, 1, 0, 4);     // LW   $0,4($1)
    i_addu8  = rtype(0, 0, 8, 'h21);     // ADDU $8,$0,$0
    i_lw10   = itype('h23, 1, 10, 8);    // LW   $10,8($1)
    i_ori10  = itype('h0D, 2, 10, 1);    // ORI  $10,$2,1 (rt not a source)
    i_beq    = itype('h04, 2, 10, 3);    // BEQ  $2,$10
    i_sw     = itype('h2B, 2, 10, 0);    // SW   $10,0($2)
    i_bad    = rtype(3, 4, 13, 'h3F);    // undefined funct
    i_addu12 = rtype(10, 3, 12, 'h21);   // ADDU $12,$10,$3
    i_jal    = {6'h03, 26'h40};
    i_halt   = 32'hFC00_0000;
    i_addi   = itype('h08, 1, 9, 5);     // ADDI $9,$1,5

    //   name           rst en fl instr     stage2  stage1  stage0  vld     dec     hz  halt
    cyc("reset",        0, 1, 0, i_addu,   Z,      Z,      Z,      3'b000, C_ADDU, 0, 0);
    cyc("rst_over_en",  1, 1, 0, i_addu,   Z,      Z,      Z,      3'b000, C_ADDU, 0, 0);
    cyc("addu_s0",      1, 1, 0, i_ori,    Z,      Z,      C_ADDU, 3'b001, C_ORI,  0, 0);
    cyc("ori_s0",       1, 1, 0, i_lw5,    Z,      C_ADDU, C_ORI,  3'b011, C_LW,   0, 0);
    cyc("load_use",     1, 1, 0, i_addu6,  C_ADDU, C_ORI,  C_LW,   3'b111, C_ADDU, 1, 0);
    cyc("stall_bubble", 1, 1, 0, i_addu6,  C_ORI,  C_LW,   Z,      3'b110, C_ADDU, 0, 0);
    cyc("stall_release",1, 1, 0, i_lw0,    C_LW,   Z,      C_ADDU, 3'b101, C_LW,   0, 0);
    cyc("lw_r0",        1, 1, 0, i_addu8,  Z,      C_ADDU, C_LW,   3'b011, C_ADDU, 0, 0);
    cyc("lw10_next",    1, 1, 0, i_lw10,   C_ADDU, C_LW,   C_ADDU, 3'b111, C_LW,   0, 0);
    cyc("rt_not_src",   1, 0, 0, i_ori10,  C_LW,   C_ADDU, C_LW,   3'b111, C_ORI,  0, 0);
    cyc("hold1_beq",    1, 0, 0, i_beq,    C_LW,   C_ADDU, C_LW,   3'b111, C_BEQ,  1, 0);
    cyc("hold2_sw",     1, 0, 0, i_sw,     C_LW,   C_ADDU, C_LW,   3'b111, C_SW,   1, 0);
    cyc("hold3_badfn",  1, 0, 0, i_bad,    C_LW,   C_ADDU, C_LW,   3'b111, C_AND,  0, 0);
    cyc("hold4_flush",  1, 1, 1, i_addu12, C_LW,   C_ADDU, C_LW,   3'b111, C_ADDU, 0, 0);
    cyc("flush_bubble", 1, 1, 0, i_jal,    C_ADDU, C_LW,   Z,      3'b110, C_JAL,  0, 0);
    cyc("jal_s0",       1, 1, 0, i_halt,   C_LW,   Z,      C_JAL,  3'b101, C_HLT,  0, 0);
    cyc("halt_s0",      1, 1, 0, i_addi,   Z,      C_JAL,  C_HLT,  3'b011, C_ADDI, 0, 0);
    cyc("halt_s1",      1, 1, 0, i_addi,   C_JAL,  C_HLT,  Z,      3'b110, C_ADDI, 0, !DRAIN);
    cyc("halt_s2",      1, 1, 0, i_addi,   C_HLT,  Z,      Z,      3'b100, C_ADDI, 0, !DRAIN);
    cyc("halt_drained", 1, 1, 0, i_addi,   Z,      Z,      Z,      3'b000, C_ADDI, 0, 1);
    cyc("halt_sticky",  0, 1, 0, i_addi,   Z,      Z,      Z,      3'b000, C_ADDI, 0, 1);
    cyc("halt_reset",   1, 1, 0, i_addi,   Z,      Z,      Z,      3'b000, C_ADDI, 0, 0);
    cyc("addi_s0",      1, 1, 0, 32'd0,    Z,      Z,      C_ADDI, 3'b001, NOP,    0, 0);
    cyc("nop_s0",       0, 1, 1, 32'd0,    Z,      C_ADDI, NOP,    3'b011, NOP,    0, 0);
    cyc("drain_reset",  1, 0, 0, 32'd0,    Z,      Z,      Z,      3'b000, NOP,    0, 0);

    repeat (3) @(posedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_control_unit.md
PIPE_CONTROL_UNIT -- requirements
Module: pipe_control_unit

Interface
REQ-001 The block SHALL have one parameter per line (name, default, meaning): STAGES, 3, number of registered control stages after decode (legal 1..4; stage 0 = EX).
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-low, on the ports named below.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset.
- instr  in  32  decode-stage instruction word (cpu_types_pkg field layout).
- en  in  1  pipeline advance enable from the datapath.
- flush  in  1  squash the decode slot (taken branch or jump).
- dec_cw  out  17  combinational control word for instr.
- cw_q  out  17*STAGES  registered control words; stage k at bits [17k+16:17k].
- vld_q  out  STAGES  per-stage valid bits.
- hz_stall  out  1  load-use stall request to fetch/PC.
- halt  out  1  sticky halt.

Function
REQ-004 The control word SHALL be laid out as: [3:0] ALUOP, [4] ALUSrc, [5] ExtOp, [7:6] RegDest, [8] RegWEN, [10:9] MemtoReg, [11] dmemREN, [12] dmemWEN, [14:13] PCSrc, [15] halt, [16] branch.
- PCSrc: 11 for JR, 10 for J/JAL, 01 for BEQ/BNE, 00 otherwise.
- branch: 1 for BEQ only.
REQ-005 dec_cw SHALL decode the full cpu_types_pkg opcode/funct set with the team single-cycle mapping:
- RegDest: 0 for RTYPE, 2 for JAL, 1 otherwise.
- RegWEN: 0 for JR, BEQ, BNE, SW, J and HALT.
- MemtoReg: 1 for LW, 2 for LUI, 3 for JAL.
- ALUOP: SUB for branches; ADD for ADDI, ADDIU, LW and SW.
- Unknown funct SHALL decode to ALU_AND.
REQ-006 A bubble SHALL be an all-zero control word with valid bit 0.
REQ-007 The block SHALL store a 5-bit destination register per stage:
- rt when RegDest=1; rd when RegDest=0; 31 when RegDest=2.
- 0 when RegWEN=0.
REQ-008 While en=1 on a rising edge, stage k SHALL load stage k-1 for k>=1, and stage 0 SHALL load:
- a bubble if flush=1;
- otherwise a bubble if hz_stall=1;
- otherwise a bubble if a HALT has already been accepted;
- otherwise dec_cw with valid=1.
REQ-009 While en=0, all stages, destination registers and valid bits SHALL hold their values.
REQ-010 hz_stall SHALL be combinational, and SHALL be 1 when all of the following hold:
- stage 0 is valid;
- stage 0 dmemREN=1;
- stage 0 destination register is nonzero;
- that register equals instr rs, or equals instr rt for an instruction that reads rt (RTYPE, BEQ, BNE, SW).
REQ-011 flush=1 SHALL take priority over hz_stall, and hz_stall SHALL be 0 in any cycle where flush=1.
REQ-012 A HALT SHALL be accepted when it enters stage 0; every later stage-0 load SHALL be a bubble until reset.
REQ-013 Once asserted, halt SHALL remain 1 until nRST=0.
REQ-014 Latency: dec_cw SHALL be 0 cycles from instr; cw_q stage k SHALL be k+1 enabled edges after decode.

Reset
REQ-015 When nRST=0 at a rising edge, the block SHALL clear all of the following:
- cw_q = 0, vld_q = 0, destination registers = 0;
- halt = 0 and the accepted-HALT flag = 0.
REQ-016 Reset SHALL dominate en and flush, and a reset mid-drain SHALL discard all in-flight stages.
REQ-017 hz_stall SHALL be 0 out of reset, because all stages are invalid.

Configuration
REQ-018 Macro CU_HALT_DRAIN_EN SHALL control when halt asserts:
- defined: halt asserts on the edge where the HALT control word leaves stage STAGES-1, i.e. after the pipeline drains;
- undefined: halt asserts on the edge after the HALT control word enters stage 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios, STAGES=3:
- ADDU then ORI with en=1: cw_q stage 0 shows ALUOP=ADD, RegDest=0, RegWEN=1, then ALUOP=OR, ExtOp=0, ALUSrc=1; each reaches stage 2 two edges later.
- LW $5 in stage 0 with decode ADDU $6,$5,$7: hz_stall=1 and a bubble is inserted; the next edge releases the stall.
- LW $0 in stage 0 with decode reading $0: hz_stall=0.
- flush=1 together with a load-use condition: stage 0 gets a bubble and hz_stall=0.
- en=0 for 4 cycles mid-stream: cw_q and vld_q are unchanged.
- HALT, then ADDI: ADDI becomes a bubble; halt rises 1 edge after the HALT enters stage 0 without CU_HALT_DRAIN_EN, or after it leaves stage 2 with it; nRST=0 then clears halt.
